// File: rtl/program_counter.sv
// rtl/program_counter.sv - PC register with sequential, branch and jump next-PC selection
module program_counter #(
  parameter int unsigned PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] PC,
  input  logic [31:0]         extend_immt_Value,
  input  logic                Branch,
  input  logic                zero,
  input  logic                signalJump,
  input  logic [25:0]         jump_Address
);

  // State register; the name stays fixed so benches can reach it hierarchically.
  logic [PC_WIDTH-1:0] programcounter;
  logic [PC_WIDTH-1:0] pc_d;

  logic [PC_WIDTH-1:0] pc_plus4;
  logic [31:0]         pc_plus4_ext;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] jump_target;

  // The 32-bit view of pc_plus4 feeds both the branch adder and the
  // pseudo-direct jump, so narrow PCs keep the full-width address semantics.
  assign pc_plus4      = programcounter + PC_WIDTH'(4);
  assign pc_plus4_ext  = 32'(pc_plus4);
  assign branch_target = PC_WIDTH'(pc_plus4_ext + (extend_immt_Value << 2));
  assign jump_target   = PC_WIDTH'({pc_plus4_ext[31:28], jump_Address, 2'b00});

  // Next-PC priority: jump over taken branch over sequential.
  always_comb begin
    pc_d = pc_plus4;
    if (signalJump) begin
      pc_d = jump_target;
    end else if (Branch && zero) begin
      pc_d = branch_target;
    end
  end

  // PC register with asynchronous reset to RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      programcounter <= RESET_PC;
    end else begin
      programcounter <= pc_d;
    end
  end

  assign PC = programcounter;

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - directed and random scoreboard bench for program_counter
module tb_program_counter;

  logic        clk;
  logic        rst_n;
  logic [7:0]  PC;
  logic [31:0] extend_immt_Value;
  logic        Branch;
  logic        zero;
  logic        signalJump;
  logic [25:0] jump_Address;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  program_counter #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .PC                (PC),
    .extend_immt_Value (extend_immt_Value),
    .Branch            (Branch),
    .zero              (zero),
    .signalJump        (signalJump),
    .jump_Address      (jump_Address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: PC=0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Drive inputs now, record the expected PC, then compare just after the next edge.
  task automatic step(input logic sj, input logic b, input logic z,
                      input logic [31:0] imm, input logic [25:0] ja,
                      input logic [7:0] exp, input string tag);
    logic [7:0] want;
    signalJump        = sj;
    Branch            = b;
    zero              = z;
    extend_immt_Value = imm;
    jump_Address      = ja;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check(tag, PC, want);
  endtask

  // Assert reset mid-cycle, confirm it acts at once and holds over an edge, release at negedge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check({tag, "_async"}, PC, 8'h00);
    @(posedge clk);
    #1;
    check({tag, "_hold"}, PC, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0]  model_pc;
    logic        sj, b, z;
    logic [31:0] imm;
    logic [25:0] ja;
    logic [7:0]  exp;

    rst_n             = 1'b0;
    signalJump        = 1'b0;
    Branch            = 1'b0;
    zero              = 1'b0;
    extend_immt_Value = 32'h0;
    jump_Address      = 26'h0;

    #2;
    check("reset_initial", PC, 8'h00);
    @(posedge clk);
    #1;
    check("reset_held_edge1", PC, 8'h00);
    @(posedge clk);
    #1;
    check("reset_held_edge2", PC, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential increments
    step(0, 0, 0, 32'h0, 26'h0, 8'h04, "seq_1");
    step(0, 0, 0, 32'h0, 26'h0, 8'h08, "seq_2");
    step(0, 0, 0, 32'h0, 26'h0, 8'h0C, "seq_3");

    // Reset after PC has moved
    do_reset("reset_mid");

    // Branch taken twice, second wraps (0x88 + 0x80 = 0x108)
    step(0, 1, 1, 32'h20, 26'h15, 8'h84, "br_taken_1");
    step(0, 1, 1, 32'h20, 26'h15, 8'h08, "br_taken_wrap");

    // Branch not taken: zero=0
    do_reset("reset_nt1");
    step(0, 1, 1, 32'h20, 26'h15, 8'h84, "br_taken_pre_nt1");
    step(0, 1, 0, 32'h20, 26'h15, 8'h88, "br_nt_zero0");

    // Not a branch though zero=1
    do_reset("reset_nt2");
    step(0, 1, 1, 32'h20, 26'h15, 8'h84, "br_taken_pre_nt2");
    step(0, 0, 1, 32'h20, 26'h15, 8'h88, "br_nt_branch0");

    // Negative branch offset from 0x10
    step(1, 0, 0, 32'h0, 26'h4, 8'h10, "jump_to_10");
    step(0, 1, 1, 32'hFFFF_FFFE, 26'h15, 8'h0C, "br_negative");

    // Jump priority over taken branch, upper field bits discarded
    step(1, 1, 1, 32'h20, 26'h15, 8'h54, "jump_priority");
    step(1, 1, 1, 32'h20, 26'h3FF_FFFF, 8'hFC, "jump_all_ones");
    step(0, 0, 0, 32'h0, 26'h3FF_FFFF, 8'h00, "seq_wrap_FC");

    // Random mix against an independent next-PC model
    model_pc = 8'h00;
    for (int i = 0; i < 40; i++) begin
      sj  = ($urandom_range(0, 3) == 0);
      b   = $urandom_range(0, 1);
      z   = $urandom_range(0, 1);
      imm = {{16{1'b0}}, 16'($urandom)};
      if (imm[15]) imm[31:16] = 16'hFFFF;
      ja  = 26'($urandom);
      if (sj)
        exp = {ja[5:0], 2'b00};
      else if (b && z)
        exp = model_pc + 8'd4 + {imm[5:0], 2'b00};
      else
        exp = model_pc + 8'd4;
      step(sj, b, z, imm, ja, exp, "random");
      model_pc = exp;
    end

    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
